fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the UART TX FIFO write port between several byte producers, such as the command parser, status reporter and debug tap. It grants one requester at a time and holds that grant for a whole packet, or until a burst limit is reached, so that bytes from different requesters never interleave. It drives the FIFO `wenb`/`dinA` inputs directly and throttles producers on FIFO full. The block runs entirely in the FIFO write clock domain.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `DW`, 8: data width; equals the FIFO width.
- `MAXBURST`, 16: maximum accepted beats per grant (1..255).

Ports:
- `clka`  in  1  write clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NREQ  per-requester byte valid.
- `req_data`  in  NREQ*DW  packed bytes; requester i occupies bits [i*DW +: DW].
- `req_last`  in  NREQ  marks the final byte of a packet; qualified by valid.
- `req_ready`  out  NREQ  per-requester accept, one-hot or zero.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_wenb`  out  1  FIFO write enable.
- `fifo_din`  out  DW  FIFO write data.
- `grant_id`  out  clog2(NREQ)  current owner index.
- `busy`  out  1  high while a grant is held.

## Operation
- The FSM has two states, IDLE and GRANT. Registers are `state`, `owner`, `last_owner`, `beats` (8 bit), `grant_id` and `busy`.
- IDLE:
  - If any `req_valid` bit is set, select the first set bit scanning `last_owner+1`, `last_owner+2`, and so on, modulo NREQ.
  - Load `owner` and `grant_id` with that index, clear `beats`, set `busy`, and go to GRANT.
  - If no bit is set, stay in IDLE.
- GRANT:
  - `req_ready[owner] = !fifo_full`. All other `req_ready` bits are 0.
  - A beat is accepted when `req_valid[owner] && req_ready[owner]`.
  - On an accepted beat, `beats` increments.
  - The grant releases on an accepted beat that has `req_last[owner]=1`, or on the accepted beat that brings `beats` to MAXBURST.
  - On release: `last_owner <= owner`, `busy <= 0`, and the FSM returns to IDLE.
- Combinational outputs:
  - `fifo_wenb` = accepted beat.
  - `fifo_din` = `req_data` of `owner` in GRANT; 0 in IDLE.
  - Full gating is combinational, so a write is never issued while `fifo_full` is high.
- Boundary conditions:
  - Owner drops valid mid-packet: the grant is held and nothing is written. Producers must not abandon packets.
  - `fifo_full` high: beats stall and `beats` is unchanged. The grant is held until space is available.
  - MAXBURST release without `req_last`: the packet resumes when that requester next wins arbitration.
  - Non-owner valids are ignored until the next IDLE cycle.
  - `req_last` on a non-accepted cycle has no effect.

## Timing
- Reset values:
  - `state` is IDLE, `owner` and `grant_id` are 0, `last_owner` is NREQ-1 (so requester 0 wins first), `beats` is 0, `busy` is 0.
  - Combinationally: `req_ready` is 0, `fifo_wenb` is 0, `fifo_din` is 0.
- Arbitration latency: 1 cycle. Valid seen in IDLE at edge N gives GRANT, with `req_ready` available, from edge N onward. The first write can occur in the cycle after the request was first seen.
- Throughput in GRANT: 1 byte/cycle when the FIFO is not full.
- Each release costs exactly one IDLE bubble cycle. This gives the maximum sustained packet rate.
- Reset asserted mid-burst:
  - Immediately: the FSM aborts to IDLE, `fifo_wenb` and all `req_ready` go to 0, and no partial write occurs after reset assertion.
  - Rotation state is lost.

## Configuration
- `FIFO_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority. The IDLE scan always starts at index 0, so the lowest index wins, and `last_owner` is unused.
  - Undefined (default): round-robin as described above.
- Burst limit and packet hold behave the same in both modes.

## Test plan
- Reset: hold `rst=0` with `req_valid=4'b1111` → `req_ready=0`, `fifo_wenb=0`, `busy=0`, `grant_id=0`. After release, requester 0 is granted first.
- Single packet: requester 2 sends 0xA1, 0xA2, 0xA3 (last on 0xA3) with `fifo_full=0` → three consecutive `fifo_wenb` pulses with `fifo_din` 0xA1..0xA3, then `busy=0` for one IDLE cycle.
- Round-robin: all four requesters send 1-byte packets continuously → grant order 0,1,2,3,0,1, with one write every 2 cycles. With the macro defined, only requester 0 is granted.
- Full stall: requester 1 sends 0x10, 0x11, 0x12 (last on 0x12), with `fifo_full=1` for 5 cycles after the first byte → `fifo_wenb=0` and `req_ready[1]=0` during the stall. 0x11 is written on the first cycle with `fifo_full=0`, and no byte is lost or duplicated.
- Burst limit: MAXBURST=4, requester 0 sends 10 bytes with `req_last` only on byte 10, requester 3 sends 1 byte → writes are bytes 1-4 of requester 0, the requester 3 byte, bytes 5-8 of requester 0, then bytes 9-10.
- Mid-burst reset: assert `rst` after 2 of 5 bytes → `fifo_wenb` drops immediately. After deassertion, requester 0 is granted first.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundles the producer-side byte handshakes and the FIFO write-port signals
// used by fifo_wr_arbiter.
//
// Handshake: a byte on requester i transfers on a rising clka edge where
// req_valid[i] && req_ready[i]. req_data/req_last of requester i are only
// meaningful while req_valid[i] is high. A producer that has started a packet
// keeps offering the rest of it; valid may drop for a while but the packet is
// never abandoned. fifo_wenb is asserted only when fifo_full is low.
//
// Signals:
//   req_valid [NREQ]     producer byte valid
//   req_data  [NREQ*DW]  packed bytes, requester i at [i*DW +: DW]
//   req_last  [NREQ]     final byte of a packet
//   req_ready [NREQ]     per-requester accept, one-hot or zero
//   fifo_full            FIFO full flag
//   fifo_wenb            FIFO write enable
//   fifo_din  [DW]       FIFO write data
//   grant_id  [IW]       current owner index
//   busy                 a grant is held
// Modports: slave = arbiter side, master = producer/FIFO side.
// -----------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_ready;
    logic               fifo_full;
    logic               fifo_wenb;
    logic [DW-1:0]      fifo_din;
    logic [IW-1:0]      grant_id;
    logic               busy;

    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_wenb, fifo_din, grant_id, busy
    );

    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_wenb, fifo_din, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Shares the UART TX FIFO write port between NREQ byte producers. One
// requester owns the port at a time and keeps it until its packet ends
// (req_last accepted) or MAXBURST beats have been accepted, so bytes of
// different requesters never interleave. Each release returns to IDLE for
// exactly one cycle, during which the next owner is chosen.
//
// Arbitration: round-robin starting after the previous owner. With
// FIFO_ARB_FIXED_PRIO_EN defined the scan always starts at index 0 (lowest
// index wins) and no rotation state is kept.
//
// Ports:
//   clka         in   write clock, rising edge
//   rst          in   asynchronous, active-low reset
//   bus          slave modport of fifo_wr_arbiter_if (handshakes, FIFO port,
//                grant_id, busy)
//   dbg_state_o  out  FSM state, 0 = IDLE, 1 = GRANT
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NREQ     = 4,
    parameter int DW       = 8,
    parameter int MAXBURST = 16
) (
    input  logic             clka,
    input  logic             rst,
    fifo_wr_arbiter_if.slave bus,
    output logic             dbg_state_o
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state_q;
    logic [IW-1:0] owner_q;
    logic [IW-1:0] grant_id_q;
    logic [7:0]    beats_q;
    logic [7:0]    beats_d;
    logic          busy_q;
`ifndef FIFO_ARB_FIXED_PRIO_EN
    logic [IW-1:0] last_owner_q;
`endif

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          owner_valid;
    logic          owner_last;
    logic [DW-1:0] owner_data;
    logic          accept;
    logic          release_now;

    // First requesting index in scan order.
    always_comb begin : pick
        logic [IW-1:0] idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = '0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
            idx = IW'(k);
`else
            idx = IW'((int'(last_owner_q) + 1 + k) % NREQ);
`endif
            if (!pick_found && bus.req_valid[idx]) begin
                pick_found = 1'b1;
                pick_idx   = idx;
            end
        end
    end

    // Owner's lane of the request bus.
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == IW'(i)) begin
                owner_valid = bus.req_valid[i];
                owner_last  = bus.req_last[i];
                owner_data  = bus.req_data[i*DW +: DW];
            end
        end
    end

    // Full gating is combinational so no write can be issued while full.
    assign accept      = (state_q == GRANT) && owner_valid && !bus.fifo_full;
    assign beats_d     = beats_q + 8'd1;
    assign release_now = accept && (owner_last || (beats_d == 8'(MAXBURST)));

    always_comb begin
        bus.req_ready = '0;
        if ((state_q == GRANT) && !bus.fifo_full) begin
            bus.req_ready[owner_q] = 1'b1;
        end
    end

    assign bus.fifo_wenb = accept;
    assign bus.fifo_din  = (state_q == GRANT) ? owner_data : '0;
    assign bus.grant_id  = grant_id_q;
    assign bus.busy      = busy_q;
    assign dbg_state_o   = (state_q == GRANT);

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            grant_id_q   <= '0;
            beats_q      <= '0;
            busy_q       <= 1'b0;
`ifndef FIFO_ARB_FIXED_PRIO_EN
            // Requester 0 wins the first scan after reset.
            last_owner_q <= IW'(NREQ - 1);
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        owner_q    <= pick_idx;
                        grant_id_q <= pick_idx;
                        beats_q    <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= GRANT;
                    end
                end
                GRANT: begin
                    if (accept) begin
                        beats_q <= beats_d;
                        if (release_now) begin
`ifndef FIFO_ARB_FIXED_PRIO_EN
                            last_owner_q <= owner_q;
`endif
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int MAXB  = 4;
    localparam int IW    = 2;
    localparam int W     = IW + DW;
    localparam int DEPTH = 1024;

    // ---------------- clock / reset ----------------
    logic clka = 1'b0;
    logic rst  = 1'b0;
    logic dbg_state;
    always #5 clka = ~clka;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus();

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAXBURST(MAXB)) dut (
        .clka        (clka),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    // Per-requester byte stream {last, data}; driver and model walk it with
    // their own read pointers.
    logic [DW:0] src_mem [NREQ][DEPTH];
    int drv_wr [NREQ];
    int drv_rd [NREQ];
    int mdl_rd [NREQ];
    logic [NREQ-1:0] acc = '0;
    int valid_pct = 100;
    int full_pct  = 0;
    logic full_script[$];

    logic [W-1:0] exp_q[$];
    logic [W-1:0] wr_log[$];

    // Reference model: who holds the port and how many bytes it has written.
    logic          m_busy       = 1'b0;
    logic [IW-1:0] m_owner      = '0;
    logic [IW-1:0] m_last_owner = IW'(NREQ - 1);
    int            m_cnt        = 0;
    logic          cur_busy     = 1'b0;
    logic          cur_wr       = 1'b0;
    logic [IW-1:0] cur_owner    = '0;

    function automatic logic [W-1:0] mk(int id, int d);
        return {IW'(id), DW'(d)};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_log(string name, int idx, logic [W-1:0] req);
        checks++;
        if (idx >= wr_log.size()) begin
            errors++;
            $display("FAIL %s[%0d]: no write logged, required %0h", name, idx, req);
        end else if (wr_log[idx] !== req) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h required %0h", name, idx, wr_log[idx], req);
        end
    endtask

    task automatic add_byte(int id, int d, bit last);
        src_mem[id][drv_wr[id] % DEPTH] = {last, DW'(d)};
        drv_wr[id]++;
    endtask

    task automatic drop_streams();
        for (int i = 0; i < NREQ; i++) begin
            drv_rd[i] = drv_wr[i];
            mdl_rd[i] = drv_wr[i];
        end
    endtask

    task automatic do_reset(int n);
        @(negedge clka);
        #3;
        rst = 1'b0;
        drop_streams();
        full_script.delete();
        repeat (n) @(negedge clka);
        rst = 1'b1;
        #3;
        wr_log.delete();
    endtask

    task automatic wait_drain(string name, int budget);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clka);
            #3;
            done = !m_busy && (exp_q.size() == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (drv_rd[i] != drv_wr[i] || mdl_rd[i] != drv_wr[i]) done = 1'b0;
            end
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_%s: still active after %0d cycles, required idle", name, budget);
        end
    endtask

    // ---------------- driver + reference model ----------------
    always @(negedge clka) begin
        logic [NREQ-1:0]    v;
        logic [NREQ-1:0]    l;
        logic [NREQ*DW-1:0] d;
        logic [DW:0]        e;
        bit                 found;
        int                 c;
        if (!rst) acc = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) drv_rd[i]++;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (drv_rd[i] < drv_wr[i] && $urandom_range(99) < valid_pct) begin
                e = src_mem[i][drv_rd[i] % DEPTH];
                v[i] = 1'b1;
                l[i] = e[DW];
                d[i*DW +: DW] = e[DW-1:0];
            end else begin
                v[i] = 1'b0;
                l[i] = 1'($urandom_range(1));
                d[i*DW +: DW] = DW'($urandom);
            end
        end
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
        if (full_script.size() > 0) bus.fifo_full = full_script.pop_front();
        else bus.fifo_full = ($urandom_range(99) < full_pct);

        #1;
        if (!rst) begin
            m_busy       = 1'b0;
            m_owner      = '0;
            m_last_owner = IW'(NREQ - 1);
            m_cnt        = 0;
        end
        cur_busy  = m_busy;
        cur_owner = m_owner;
        cur_wr    = 1'b0;
        if (rst) begin
            if (!m_busy) begin
                found = 1'b0;
                for (int k = 0; k < NREQ; k++) begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
                    c = k;
`else
                    c = (int'(m_last_owner) + 1 + k) % NREQ;
`endif
                    if (!found && bus.req_valid[c]) begin
                        found   = 1'b1;
                        m_busy  = 1'b1;
                        m_owner = IW'(c);
                        m_cnt   = 0;
                    end
                end
            end else if (bus.req_valid[m_owner] && !bus.fifo_full) begin
                e = src_mem[m_owner][mdl_rd[m_owner] % DEPTH];
                mdl_rd[m_owner]++;
                cur_wr = 1'b1;
                exp_q.push_back({m_owner, e[DW-1:0]});
                m_cnt++;
                if (e[DW] || m_cnt == MAXB) begin
                    m_busy       = 1'b0;
                    m_last_owner = m_owner;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clka) begin
        logic [NREQ-1:0] exp_rdy;
        logic [W-1:0]    w;
        #2;
        acc = bus.req_valid & bus.req_ready & {NREQ{rst}};
        check("wenb", bus.fifo_wenb, cur_wr);
        if (bus.fifo_wenb) begin
            wr_log.push_back({bus.grant_id, bus.fifo_din});
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL write: got %0h with nothing expected at %0t",
                         {bus.grant_id, bus.fifo_din}, $time);
            end else begin
                w = exp_q.pop_front();
                check("write", {bus.grant_id, bus.fifo_din}, w);
            end
        end
        check("busy", bus.busy, cur_busy);
        check("dbg_state", dbg_state, cur_busy);
        check("grant_id", bus.grant_id, cur_owner);
        exp_rdy = '0;
        if (cur_busy && !bus.fifo_full) exp_rdy[cur_owner] = 1'b1;
        check("req_ready", bus.req_ready, exp_rdy);
        if (!cur_busy) check("din_idle", bus.fifo_din, 0);
        if (bus.fifo_full) check("wenb_when_full", bus.fifo_wenb, 0);
    end

    // ---------------- test sequence ----------------
    initial begin
        int base;
        int n;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;

        // Reset with every requester valid.
        for (int i = 0; i < NREQ; i++) add_byte(i, i, 1'b1);
        repeat (3) @(negedge clka);
        #3;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_wenb", bus.fifo_wenb, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_grant_id", bus.grant_id, 0);
        check("rst_din", bus.fifo_din, 0);
        @(negedge clka);
        rst = 1'b1;
        wait_drain("reset", 50);
        for (int i = 0; i < NREQ; i++) begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
            check_log("first_grant", i, mk(i, i));
`else
            check_log("first_grant", i, mk(i, i));
`endif
        end

        // Single packet on requester 2.
        do_reset(2);
        add_byte(2, 8'hA1, 1'b0);
        add_byte(2, 8'hA2, 1'b0);
        add_byte(2, 8'hA3, 1'b1);
        wait_drain("single", 50);
        check_log("single", 0, mk(2, 8'hA1));
        check_log("single", 1, mk(2, 8'hA2));
        check_log("single", 2, mk(2, 8'hA3));

        // Continuous 1-byte packets from all requesters.
        do_reset(2);
        for (int j = 0; j < 6; j++)
            for (int i = 0; i < NREQ; i++) add_byte(i, 8'h40 + j * 4 + i, 1'b1);
        wait_drain("round_robin", 200);
        for (int k = 0; k < 6; k++) begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
            check_log("order", k, mk(0, 8'h40 + k * 4));
`else
            check_log("order", k, mk(k % 4, 8'h40 + (k / 4) * 4 + (k % 4)));
`endif
        end

        // Full stall after the first byte of requester 1.
        do_reset(2);
        full_script = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        add_byte(1, 8'h10, 1'b0);
        add_byte(1, 8'h11, 1'b0);
        add_byte(1, 8'h12, 1'b1);
        wait_drain("full_stall", 50);
        check_log("stall", 0, mk(1, 8'h10));
        check_log("stall", 1, mk(1, 8'h11));
        check_log("stall", 2, mk(1, 8'h12));
        checks++;
        if (wr_log.size() != 3) begin
            errors++;
            $display("FAIL stall_count: got %0d writes required 3", wr_log.size());
        end

        // Burst limit: 10-byte packet on 0 competing with 1 byte on 3.
        do_reset(2);
        for (int b = 1; b <= 10; b++) add_byte(0, 8'h80 + b, b == 10);
        add_byte(3, 8'hC3, 1'b1);
        wait_drain("burst", 100);
`ifdef FIFO_ARB_FIXED_PRIO_EN
        for (int b = 1; b <= 10; b++) check_log("burst", b - 1, mk(0, 8'h80 + b));
        check_log("burst", 10, mk(3, 8'hC3));
`else
        for (int b = 1; b <= 4; b++) check_log("burst", b - 1, mk(0, 8'h80 + b));
        check_log("burst", 4, mk(3, 8'hC3));
        for (int b = 5; b <= 10; b++) check_log("burst", b, mk(0, 8'h80 + b));
`endif

        // Reset asserted in the middle of a 5-byte packet.
        do_reset(2);
        for (int b = 1; b <= 5; b++) add_byte(0, 8'hE0 + b, b == 5);
        n = 0;
        while (wr_log.size() < 2 && n < 50) begin
            @(negedge clka);
            #3;
            n++;
        end
        check("mid_two_writes", (wr_log.size() >= 2), 1);
        @(negedge clka);
        #3;
        check("mid_wenb_before", bus.fifo_wenb, 1);
        rst = 1'b0;
        drop_streams();
        #1;
        check("mid_wenb_after", bus.fifo_wenb, 0);
        check("mid_ready_after", bus.req_ready, 0);
        check("mid_busy_after", bus.busy, 0);
        base = wr_log.size();
        add_byte(1, 8'hF1, 1'b1);
        add_byte(0, 8'hF0, 1'b1);
        repeat (2) @(negedge clka);
        rst = 1'b1;
        wait_drain("mid_reset", 50);
        check_log("after_reset", base, mk(0, 8'hF0));
        check_log("after_reset", base + 1, mk(1, 8'hF1));
        check("mid_total", wr_log.size(), base + 2);

        // Random traffic with random valid gaps and FIFO full.
        do_reset(2);
        valid_pct = 75;
        full_pct  = 25;
        for (int cyc = 0; cyc < 800; cyc++) begin
            int id;
            int len;
            @(negedge clka);
            #3;
            id  = $urandom_range(NREQ - 1);
            len = $urandom_range(7, 1);
            if ($urandom_range(2) == 0 && (drv_wr[id] - drv_rd[id]) < 32) begin
                for (int b = 0; b < len; b++) add_byte(id, $urandom_range(255), b == len - 1);
            end
        end
        valid_pct = 100;
        full_pct  = 0;
        wait_drain("random", 3000);
        check("exp_q_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
